// File: rtl/bitonic_block_pkg.sv
// Shared definitions for the bitonic merge block: sort direction and pair indexing.
package bitonic_block_pkg;

    // Direction of one compare-exchange: which of the pair lands on the lower index.
    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } sort_dir_t;

    // Lower element index of the p-th compare pair in a layer with half-distance h.
    // Pairs are numbered densely over the elements whose (j mod 2h) < h.
    function automatic int pair_lo_index(input int p, input int h);
        return (p / h) * (2 * h) + (p % h);
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-and-swap of two unsigned elements.
// lo feeds the lower element index, hi the upper one. Ascending puts the minimum on lo,
// descending puts the maximum on lo. Equal values pass straight through.
module bitonic_cas
    import bitonic_block_pkg::*;
#(
    parameter int        DATA_WIDTH = 8,
    parameter sort_dir_t DIR        = DIR_ASC
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic swap;

    // Swap only on strict disorder so ties keep their positions.
    always_comb begin
        swap = (DIR == DIR_ASC) ? (a > b) : (a < b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/bitonic_block.sv
// Pipelined bitonic merge of N = 2**BLOCK_DEPTH unsigned elements.
// One registered compare-exchange layer per level; a parallel valid shift register
// marks which data_out words came from a valid input. No backpressure: the pipeline
// advances every cycle and the consumer takes data_out whenever done is high.
module bitonic_block
    import bitonic_block_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 1,
    parameter int POLARITY    = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DATA_WIDTH*(2**BLOCK_DEPTH)-1:0] data_in,
    input  logic                                   valid,
    output logic [DATA_WIDTH*(2**BLOCK_DEPTH)-1:0] data_out,
    output logic                                   done
);

    localparam int        N   = 2 ** BLOCK_DEPTH;
    localparam int        W   = DATA_WIDTH * N;
    localparam sort_dir_t DIR = (POLARITY != 0) ? DIR_DESC : DIR_ASC;

    for (genvar l = 0; l < BLOCK_DEPTH; l++) begin : g_layer
        localparam int H = N >> (l + 1);

        logic [W-1:0] d;
        logic [W-1:0] net;
        logic [W-1:0] q;
        logic         v_in;
        logic         v;

        if (l == 0) begin : g_head
            assign d    = data_in;
            assign v_in = valid;
        end else begin : g_tail
            assign d    = g_layer[l-1].q;
            assign v_in = g_layer[l-1].v;
        end

        for (genvar p = 0; p < N / 2; p++) begin : g_pair
            localparam int J = pair_lo_index(p, H);

            bitonic_cas #(
                .DATA_WIDTH(DATA_WIDTH),
                .DIR       (DIR)
            ) u_cas (
                .a (d[DATA_WIDTH*J +: DATA_WIDTH]),
                .b (d[DATA_WIDTH*(J+H) +: DATA_WIDTH]),
                .lo(net[DATA_WIDTH*J +: DATA_WIDTH]),
                .hi(net[DATA_WIDTH*(J+H) +: DATA_WIDTH])
            );
        end

        // Layer register: data and its valid flag advance together every cycle.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                q <= net;
                v <= v_in;
            end
        end
    end

    assign data_out = g_layer[BLOCK_DEPTH-1].q;
    assign done     = g_layer[BLOCK_DEPTH-1].v;

endmodule

// File: tb/tb_bitonic_block.sv
// Bench for bitonic_block: five instances (depth 1..3, both polarities) share clock
// and reset. A sort-based model predicts every valid result; one compare task checks
// done and data_out of every instance on every cycle.
module tb_bitonic_block;

    localparam int NDUT = 5;
    localparam int HIST = 1024;

    // Instance g: depths 1,1,2,2,3 and polarities 0,1,0,1,0.
    function automatic int dep_of(input int g);
        return (g < 2) ? 1 : ((g < 4) ? 2 : 3);
    endfunction

    function automatic bit pol_of(input int g);
        return (g == 1) || (g == 3);
    endfunction

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] din  [NDUT];
    logic        vin  [NDUT];
    wire  [63:0] dout [NDUT];
    wire         dn   [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int fill [NDUT];

    logic        hist_v [NDUT][HIST];
    logic [63:0] hist_e [NDUT][HIST];

    // Clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = dep_of(g);
        localparam int W = 8 << D;
        wire [W-1:0] q;

        bitonic_block #(
            .DATA_WIDTH (8),
            .BLOCK_DEPTH(D),
            .POLARITY   (int'(pol_of(g)))
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .data_in (din[g][W-1:0]),
            .valid   (vin[g]),
            .data_out(q),
            .done    (dn[g])
        );

        assign dout[g] = 64'(q);
    end

    // Model: a bitonic input merges into the plainly sorted sequence.
    function automatic logic [63:0] model(input logic [63:0] v, input int n, input bit desc);
        int          e [8];
        int          t;
        logic [63:0] r;
        for (int k = 0; k < 8; k++) e[k] = 0;
        for (int k = 0; k < n; k++) e[k] = int'(v[8*k +: 8]);
        for (int a = 0; a < n; a++) begin
            for (int b = 0; b < n - 1 - a; b++) begin
                if (desc ? (e[b] < e[b+1]) : (e[b] > e[b+1])) begin
                    t      = e[b];
                    e[b]   = e[b+1];
                    e[b+1] = t;
                end
            end
        end
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = 8'(e[k]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard compare: output after edge c reflects the input sampled at edge c-D+1.
    task automatic compare_all();
        for (int g = 0; g < NDUT; g++) begin
            int d;
            int idx;
            d = dep_of(g);
            if (fill[g] >= d) begin
                idx = edge_cnt - d + 1;
                check($sformatf("done[%0d]@%0d", g, edge_cnt), 64'(dn[g]), 64'(hist_v[g][idx]));
                if (hist_v[g][idx])
                    check($sformatf("data[%0d]@%0d", g, edge_cnt), dout[g], hist_e[g][idx]);
            end else begin
                check($sformatf("done_fill[%0d]@%0d", g, edge_cnt), 64'(dn[g]), 64'd0);
            end
        end
    endtask

    // One clock: record what the DUTs sample, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            edge_cnt++;
            for (int g = 0; g < NDUT; g++) begin
                hist_v[g][edge_cnt] = vin[g];
                hist_e[g][edge_cnt] = model(din[g], 1 << dep_of(g), pol_of(g));
                fill[g]++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_all();
        for (int g = 0; g < NDUT; g++) begin
            din[g] = '0;
            vin[g] = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_data[%0d]", tag, g), dout[g], 64'd0);
            check($sformatf("%s_done[%0d]", tag, g), 64'(dn[g]), 64'd0);
        end
    endtask

    logic [31:0] vec2 [8];
    logic        val2 [8];

    initial begin
        for (int g = 0; g < NDUT; g++) fill[g] = 0;
        idle_all();

        // Reset state
        #3;
        check_reset_state("rst_init");
        repeat (2) tick();
        #2 reset = 1'b1;

        // Single vectors into every instance
        din[0] = 64'h0305;                vin[0] = 1'b1;
        din[1] = 64'h0305;                vin[1] = 1'b1;
        din[2] = 64'h02070401;            vin[2] = 1'b1;
        din[3] = 64'h04010207;            vin[3] = 1'b1;
        din[4] = 64'h0003080B0C090502;    vin[4] = 1'b1;
        tick();
        idle_all();
        check("d1_asc", dout[0], 64'h0503);
        check("d1_desc", dout[1], 64'h0305);
        tick();
        check("d2_asc", dout[2], 64'h07040201);
        check("d2_desc", dout[3], 64'h01020407);
        tick();
        check("d3_asc", dout[4], 64'h0C0B090805030200);
        tick();

        // Ties and extremes at depth 3
        din[4] = 64'h0707070700FFFF00; vin[4] = 1'b1;
        tick();
        idle_all();
        repeat (2) tick();
        check("d3_ties", dout[4], 64'hFFFF070707070000);
        tick();

        // Back-to-back and gapped valids at depth 2 (depth 1 sees the low pair)
        vec2 = '{32'h051E140A, 32'h3C3264C8, 32'h09090909, 32'h06FF0000,
                 32'h02012832, 32'h051E140A, 32'h3C3264C8, 32'h02012832};
        val2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 4; g++) begin
                din[g] = 64'(vec2[i]);
                vin[g] = val2[i];
            end
            tick();
            if (i == 1) check("b2b_first", dout[2], 64'h1E140A05);
        end
        idle_all();
        repeat (4) tick();

        // Reset with two inputs in flight at depth 3
        din[4] = 64'h0003080B0C090502; vin[4] = 1'b1;
        tick();
        din[4] = 64'h0707070700FFFF00;
        tick();
        idle_all();
        #2 reset = 1'b0;
        #1;
        check_reset_state("rst_async");
        for (int g = 0; g < NDUT; g++) fill[g] = 0;
        repeat (2) tick();
        #2 reset = 1'b1;
        repeat (4) tick();

        // Fresh valid after reset release
        din[4] = 64'h0003080B0C090502; vin[4] = 1'b1;
        din[2] = 64'h02070401;         vin[2] = 1'b1;
        tick();
        idle_all();
        tick();
        check("post_rst_d2", dout[2], 64'h07040201);
        tick();
        check("post_rst_d3", dout[4], 64'h0C0B090805030200);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitonic_block.md
Name: bitonic_block

Overview:
- Pipelined bitonic merge unit of N = 2^BLOCK_DEPTH unsigned elements.
- Input is a bitonic sequence: the lower half of the elements is sorted in one direction and the upper half in the other. The output is the fully sorted sequence in the direction set by POLARITY.
- Instantiated per block per stage of the bitonic sorter top; stage s uses BLOCK_DEPTH = s+1 and alternating POLARITY. Data and valid flow straight from stage to stage.

Parameters:
- DATA_WIDTH, default 8: width of one unsigned element.
- BLOCK_DEPTH, default 1: log2 of element count N. Also the number of merge layers and the latency. Legal values are 1 and up.
- POLARITY, default 0: 0 = ascending (element 0 smallest); 1 = descending (element 0 largest).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- data_in, input, DATA_WIDTH*2^BLOCK_DEPTH: N packed elements; element k occupies bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
- valid, input, 1: data_in is meaningful this cycle.
- data_out, output, DATA_WIDTH*2^BLOCK_DEPTH: merged elements, same packing as data_in.
- done, output, 1: data_out holds the result of a valid input.

Behaviour:
- Network: BLOCK_DEPTH layers, l = 0..BLOCK_DEPTH-1, with half-distance h = N >> (l+1).
  - In each layer, every element j with (j mod 2h) < h is compare-exchanged with element j+h.
  - Ascending: min goes to index j, max to index j+h. Descending: the reverse.
  - Every layer uses the same direction (POLARITY).
- Compare: unsigned, full DATA_WIDTH. Equal values are not swapped. No width growth.
- Pipeline:
  - Each layer's result is registered, giving BLOCK_DEPTH register stages. data_out is the last stage's register.
  - Latency: input sampled on clock edge t appears on data_out after edge t+BLOCK_DEPTH-1, i.e. the result is visible BLOCK_DEPTH cycles after presentation.
  - Data registers advance every cycle, whatever the value of valid.
- done:
  - A BLOCK_DEPTH-deep shift register of valid; done is its last stage.
  - done is 1 exactly when data_out corresponds to a cycle in which valid was 1.
  - done may be held high continuously.
- Throughput and handshake:
  - One new input accepted every cycle (fully pipelined).
  - No backpressure and no ready signal; the consumer must take data_out whenever done is high.
  - Holding valid and data_in constant keeps done=1 and data_out constant once the pipeline fills.
- Non-bitonic input: no error is flagged. The output is the deterministic result of the network above and is not guaranteed sorted.
- Reset:
  - While reset=0, all pipeline data registers, data_out and the done shift register are 0, asynchronously.
  - Assertion mid-operation discards all in-flight data.
  - After release, done stays 0 until a valid has propagated BLOCK_DEPTH cycles.
- The block uses no initial blocks and no simulation-only dump code.

Decomposition:
- Shared package: none required. The element-index helper (element k slice) may live locally as a function.
- One sub-module: bitonic_cas. Parameters are DATA_WIDTH and direction. It is a purely combinational two-input compare-and-swap producing lo/hi outputs.
- bitonic_block generates N/2 bitonic_cas instances per layer plus a registered stage per layer.

Test Plan:
- DATA_WIDTH=8, BLOCK_DEPTH=1, POLARITY=0: elements {e0=5, e1=3} with valid=1 for one cycle -> next cycle data_out = {3, 5}, done=1 for exactly one cycle. POLARITY=1 with same input -> {5, 3}.
- BLOCK_DEPTH=2, POLARITY=0: {1, 4, 7, 2} -> after 2 cycles {1, 2, 4, 7}, done high one cycle. POLARITY=1 with input {7, 2, 1, 4} -> {7, 4, 2, 1}.
- BLOCK_DEPTH=3, POLARITY=0: {2, 5, 9, 12, 11, 8, 3, 0} -> after 3 cycles {0, 2, 3, 5, 8, 9, 11, 12}. Also check ties and extremes: {0, 255, 255, 0, 7, 7, 7, 7}, bitonic with equal values -> ascending {0, 0, 7, 7, 7, 7, 255, 255}.
- Back-to-back input, BLOCK_DEPTH=2: valid=1 on three consecutive cycles with different bitonic vectors -> three consecutive done=1 cycles, each data_out correctly sorted and in order. Gap cycles with valid=0 -> done=0 in the matching output cycles.
- Reset:
  - Assert reset=0 while two inputs are in flight -> data_out=0 and done=0 immediately, without waiting for a clock edge.
  - After release, no done pulse until a new valid is applied.
  - A new valid then yields a correct result BLOCK_DEPTH cycles later.
